// File: rtl/updown_counter8_core.sv
// Up/down counter stepped by rising edges of the divided tick_in square wave.
// Offers load, enable, direction, wrap/saturate limiting, terminal-count pulse and limit flags.
//
// state | meaning
// IDLE  | counting disabled; steps ignored, q held
// RUN   | counting; each tick_in rise moves q one count
// LIMIT | saturated at a limit; only a step away from that limit resumes counting
module updown_counter8_core #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 255,
  parameter int MIN_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             en,
  input  logic             up,
  input  logic             wrap,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_max,
  output logic             at_min,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LIMIT = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  state_t           state_q, state_d;

  logic             step;
  logic             hi_lim;
  logic             lo_lim;
  logic             toward;
  logic [WIDTH-1:0] din_clamped;

  assign step   = sync2_q & ~prev_q;
  assign hi_lim = (q_q >= MAX_W);
  assign lo_lim = (q_q <= MIN_W);
  // In LIMIT, a step is "toward" the limit q is sitting on
  assign toward = hi_lim ? up : ~up;

  always_comb begin
    din_clamped = din;
    if (din >= MAX_W) begin
      din_clamped = MAX_W;
    end else if (din <= MIN_W) begin
      din_clamped = MIN_W;
    end
  end

  always_comb begin
    sync1_d = tick_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    q_d     = q_q;
    tc_d    = 1'b0;
    state_d = state_q;

    if (load) begin
      q_d     = din_clamped;
      state_d = en ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_d = RUN;
          end
        end

        RUN: begin
          if (!en) begin
            state_d = IDLE;
          end else if (step) begin
            if (up) begin
              if (!hi_lim) begin
                q_d = q_q + ONE_W;
              end else if (wrap) begin
                q_d  = MIN_W;
                tc_d = 1'b1;
              end else begin
                tc_d    = 1'b1;
                state_d = LIMIT;
              end
            end else begin
              if (!lo_lim) begin
                q_d = q_q - ONE_W;
              end else if (wrap) begin
                q_d  = MAX_W;
                tc_d = 1'b1;
              end else begin
                tc_d    = 1'b1;
                state_d = LIMIT;
              end
            end
          end
        end

        LIMIT: begin
          if (!en) begin
            state_d = IDLE;
          end else if (wrap) begin
            state_d = RUN;
          end else if (step && !toward) begin
            q_d     = up ? (q_q + ONE_W) : (q_q - ONE_W);
            state_d = RUN;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Synchronizer and prev reset high so a tick_in held high through reset is not a step
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      q_q     <= MIN_W;
      tc_q    <= 1'b0;
      state_q <= IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  assign q      = q_q;
  assign tc     = tc_q;
  assign at_max = (q_q == MAX_W);
  assign at_min = (q_q == MIN_W);
  assign state  = state_q;

endmodule
